// File: rtl/power_sequencer.sv
// power_sequencer: staged regulator power-up/down sequencer with timeout and external fault latching
module power_sequencer #(
  parameter int STAGE_TIMEOUT = 4160000,
  parameter int SETTLE_DELAY  = 416000,
  parameter int OFF_DELAY     = 416000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [2:0] i_stageGood,
  input  logic       i_fault,
  input  logic       i_clearFault,
  output logic [2:0] o_stageEnable,
  output logic [2:0] o_state,
  output logic       o_sequenceDone,
  output logic       o_timeoutFault,
  output logic       o_extFault,
  output logic [1:0] o_faultStage
);
  localparam int MAX_AB = (STAGE_TIMEOUT > SETTLE_DELAY) ? STAGE_TIMEOUT : SETTLE_DELAY;
  localparam int MAX_P  = (MAX_AB > OFF_DELAY) ? MAX_AB : OFF_DELAY;
  localparam int CW     = $clog2(MAX_P) + 1;
  localparam logic [CW-1:0] C_TO  = CW'(STAGE_TIMEOUT - 1);
  localparam logic [CW-1:0] C_SET = CW'(SETTLE_DELAY - 1);
  localparam logic [CW-1:0] C_OFF = CW'(OFF_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UP     = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DOWN   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t        r_state, w_state_nx;
  logic [1:0]    r_idx, w_idx_nx;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_en, w_en_nx;
  logic          r_done, r_tf, w_tf_nx, r_ef, w_ef_nx;
  logic [1:0]    r_fs, w_fs_nx;
  logic [2:0]    w_mask_cur, w_mask_inc, w_low_cur, w_low_dec;
  logic          w_loss;
  logic [1:0]    w_loss_stage;

  assign w_mask_cur = (r_idx == 2'd0) ? 3'b001 : (r_idx == 2'd1) ? 3'b011 : 3'b111;
  assign w_mask_inc = (r_idx == 2'd0) ? 3'b011 : 3'b111;
  assign w_low_cur  = (r_idx == 2'd0) ? 3'b000 : (r_idx == 2'd1) ? 3'b001 : 3'b011;
  assign w_low_dec  = (r_idx == 2'd2) ? 3'b001 : 3'b000;

  // Good-loss / timeout detection for the active states; DOWN ignores stage good
  always_comb begin
    w_loss       = 1'b0;
    w_loss_stage = r_idx;
    case (r_state)
      S_UP:     w_loss = (r_cnt == C_TO) && !i_stageGood[r_idx];
      S_SETTLE: w_loss = |(~i_stageGood & w_mask_cur);
      S_RUN: begin
        w_loss       = (i_stageGood != 3'b111);
        w_loss_stage = !i_stageGood[0] ? 2'd0 : !i_stageGood[1] ? 2'd1 : 2'd2;
      end
      default: w_loss = 1'b0;
    endcase
  end

  // Next-state and next-output decisions, highest-priority event first
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_en_nx    = r_en;
    w_tf_nx    = r_tf;
    w_ef_nx    = r_ef;
    w_fs_nx    = r_fs;
    case (r_state)
      S_IDLE: begin
        w_en_nx = 3'b000;
        if (i_enable) begin
          w_state_nx = S_UP;
          w_idx_nx   = 2'd0;
          w_en_nx    = 3'b001;
        end
      end
      S_FAULT: begin
        w_en_nx = 3'b000;
        if (i_clearFault && !i_enable) begin
          w_state_nx = S_IDLE;
          w_idx_nx   = 2'd0;
          w_tf_nx    = 1'b0;
          w_ef_nx    = 1'b0;
          w_fs_nx    = 2'd0;
        end
      end
      default: begin
        if (i_fault) begin
          w_state_nx = S_FAULT;
          w_en_nx    = 3'b000;
          w_ef_nx    = 1'b1;
          w_fs_nx    = r_idx;
        end else if (w_loss) begin
          w_state_nx = S_FAULT;
          w_en_nx    = 3'b000;
          w_tf_nx    = 1'b1;
          w_fs_nx    = w_loss_stage;
        end else if (!i_enable && r_state != S_DOWN) begin
          w_state_nx = S_DOWN;
          w_en_nx    = w_low_cur;
        end else begin
          case (r_state)
            S_UP: if (i_stageGood[r_idx]) w_state_nx = S_SETTLE;
            S_SETTLE: begin
              if (r_cnt == C_SET) begin
                w_state_nx = (r_idx == 2'd2) ? S_RUN : S_UP;
                w_idx_nx   = (r_idx == 2'd2) ? r_idx : r_idx + 2'd1;
                w_en_nx    = w_mask_inc;
              end
            end
            S_DOWN: begin
              if (r_cnt == C_OFF) begin
                w_state_nx = (r_idx == 2'd0) ? S_IDLE : S_DOWN;
                w_idx_nx   = (r_idx == 2'd0) ? 2'd0 : r_idx - 2'd1;
                w_en_nx    = w_low_dec;
              end
            end
            default: w_state_nx = r_state;
          endcase
        end
      end
    endcase
  end

  // State, stage index, saturating counter and registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_cnt   <= '0;
      r_en    <= 3'b000;
      r_done  <= 1'b0;
      r_tf    <= 1'b0;
      r_ef    <= 1'b0;
      r_fs    <= 2'd0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= (w_state_nx != r_state || w_idx_nx != r_idx) ? '0 : (&r_cnt) ? r_cnt : r_cnt + CW'(1);
      r_en    <= w_en_nx;
      r_done  <= (w_state_nx == S_RUN);
      r_tf    <= w_tf_nx;
      r_ef    <= w_ef_nx;
      r_fs    <= w_fs_nx;
    end
  end

  assign o_stageEnable  = r_en;
  assign o_state        = r_state;
  assign o_sequenceDone = r_done;
  assign o_timeoutFault = r_tf;
  assign o_extFault     = r_ef;
  assign o_faultStage   = r_fs;
endmodule

// File: tb/tb_power_sequencer.sv
// tb_power_sequencer: directed scoreboard bench for power_sequencer (16/4/8 cycle timing)
module tb_power_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] good = 3'b000;
  logic       flt = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] stage_en, state;
  logic       done, tf, ef;
  logic [1:0] fs;
  logic [10:0] obs_w;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int mark = 0;
  int last = 0;
  logic [10:0] prev;

  typedef struct {
    logic [10:0] v;
    int          d;
    string       tag;
  } exp_t;
  exp_t q[$];

  power_sequencer #(.STAGE_TIMEOUT(16), .SETTLE_DELAY(4), .OFF_DELAY(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_stageGood(good), .i_fault(flt),
    .i_clearFault(clr), .o_stageEnable(stage_en), .o_state(state), .o_sequenceDone(done),
    .o_timeoutFault(tf), .o_extFault(ef), .o_faultStage(fs)
  );

  assign obs_w = {state, stage_en, done, tf, ef, fs};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] pk(logic [2:0] s, logic [2:0] e, logic d, logic t, logic x, logic [1:0] f);
    return {s, e, d, t, x, f};
  endfunction

  task automatic ex(logic [10:0] v, int d, string t);
    q.push_back('{v, d, t});
  endtask

  task automatic chk(string t, logic [10:0] a, logic [10:0] b);
    checks++;
    assert (a === b) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, a, b);
    end
  endtask

  task automatic tick(int n);
    exp_t e;
    int   base;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (obs_w !== prev) begin
        base = (mark > last) ? mark : last;
        e = (q.size() != 0) ? q.pop_front() : '{11'bx, -1, "unexpected_change"};
        checks++;
        assert (obs_w === e.v && cyc - base == e.d) else begin
          failures++;
          $error("FAIL %s observed=%h after %0d cyc, expected=%h after %0d cyc", e.tag, obs_w, cyc - base, e.v, e.d);
        end
        last = cyc;
        prev = obs_w;
      end
    end
  endtask

  task automatic power_up();
    en = 1'b1;
    mark = cyc;
    ex(pk(3'd1, 3'b001, 0, 0, 0, 2'd0), 1, "up_s1");
    ex(pk(3'd2, 3'b001, 0, 0, 0, 2'd0), 4, "settle_s1");
    ex(pk(3'd1, 3'b011, 0, 0, 0, 2'd1 * 0), 4, "up_s2");
    ex(pk(3'd2, 3'b011, 0, 0, 0, 2'd0), 4, "settle_s2");
    ex(pk(3'd1, 3'b111, 0, 0, 0, 2'd0), 4, "up_s3");
    ex(pk(3'd2, 3'b111, 0, 0, 0, 2'd0), 4, "settle_s3");
    ex(pk(3'd3, 3'b111, 1, 0, 0, 2'd0), 4, "run");
    tick(4);
    good[0] = 1'b1;
    tick(8);
    good[1] = 1'b1;
    tick(8);
    good[2] = 1'b1;
    tick(8);
  endtask

  task automatic clear_fault();
    en = 1'b0;
    clr = 1'b1;
    mark = cyc;
    ex(pk(3'd0, 3'b000, 0, 0, 0, 2'd0), 1, "fault_clear");
    tick(1);
    clr = 1'b0;
    good = 3'b000;
    tick(3);
  endtask

  initial begin
    tick(3);
    chk("reset_state", obs_w, 11'd0);
    prev = obs_w;
    rst = 1'b0;
    tick(3);
    chk("idle_after_release", obs_w, 11'd0);

    power_up();
    en = 1'b0;
    mark = cyc;
    ex(pk(3'd4, 3'b011, 0, 0, 0, 2'd0), 1, "down_s3");
    ex(pk(3'd4, 3'b001, 0, 0, 0, 2'd0), 8, "down_s2");
    ex(pk(3'd4, 3'b000, 0, 0, 0, 2'd0), 8, "down_s1");
    ex(pk(3'd0, 3'b000, 0, 0, 0, 2'd0), 8, "down_idle");
    tick(30);
    good = 3'b000;
    tick(2);

    en = 1'b1;
    mark = cyc;
    ex(pk(3'd1, 3'b001, 0, 0, 0, 2'd0), 1, "to_up_s1");
    ex(pk(3'd2, 3'b001, 0, 0, 0, 2'd0), 4, "to_settle_s1");
    ex(pk(3'd1, 3'b011, 0, 0, 0, 2'd0), 4, "to_up_s2");
    ex(pk(3'd5, 3'b000, 0, 1, 0, 2'd1), 16, "timeout_s2");
    tick(4);
    good[0] = 1'b1;
    tick(30);
    clear_fault();

    en = 1'b1;
    mark = cyc;
    ex(pk(3'd1, 3'b001, 0, 0, 0, 2'd0), 1, "ef_up_s1");
    ex(pk(3'd2, 3'b001, 0, 0, 0, 2'd0), 4, "ef_settle_s1");
    tick(4);
    good[0] = 1'b1;
    tick(2);
    flt = 1'b1;
    mark = cyc;
    ex(pk(3'd5, 3'b000, 0, 0, 1, 2'd0), 1, "ext_fault_settle");
    tick(1);
    flt = 1'b0;
    tick(3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(4);
    chk("clear_ignored_enable_high", obs_w, pk(3'd5, 3'b000, 0, 0, 1, 2'd0));
    clear_fault();

    power_up();
    flt = 1'b1;
    en = 1'b0;
    mark = cyc;
    ex(pk(3'd5, 3'b000, 0, 0, 1, 2'd2), 1, "fault_beats_disable");
    tick(1);
    flt = 1'b0;
    tick(3);
    clear_fault();

    power_up();
    good = 3'b001;
    mark = cyc;
    ex(pk(3'd5, 3'b000, 0, 1, 0, 2'd1), 1, "run_good_loss");
    tick(4);
    clear_fault();

    en = 1'b1;
    mark = cyc;
    ex(pk(3'd1, 3'b001, 0, 0, 0, 2'd0), 1, "short_up");
    tick(2);
    en = 1'b0;
    mark = cyc;
    ex(pk(3'd4, 3'b000, 0, 0, 0, 2'd0), 1, "down_from_up");
    ex(pk(3'd0, 3'b000, 0, 0, 0, 2'd0), 8, "down_enable_ignored");
    ex(pk(3'd1, 3'b001, 0, 0, 0, 2'd0), 1, "idle_to_up_again");
    tick(3);
    en = 1'b1;
    tick(12);
    en = 1'b0;
    mark = cyc;
    ex(pk(3'd4, 3'b000, 0, 0, 0, 2'd0), 1, "down_again");
    ex(pk(3'd0, 3'b000, 0, 0, 0, 2'd0), 8, "idle_again");
    tick(12);

    en = 1'b1;
    mark = cyc;
    ex(pk(3'd1, 3'b001, 0, 0, 0, 2'd0), 1, "rst_up_s1");
    ex(pk(3'd2, 3'b001, 0, 0, 0, 2'd0), 4, "rst_settle_s1");
    ex(pk(3'd1, 3'b011, 0, 0, 0, 2'd0), 4, "rst_up_s2");
    ex(pk(3'd2, 3'b011, 0, 0, 0, 2'd0), 4, "rst_settle_s2");
    ex(pk(3'd1, 3'b111, 0, 0, 0, 2'd0), 4, "rst_up_s3");
    tick(4);
    good[0] = 1'b1;
    tick(8);
    good[1] = 1'b1;
    tick(6);
    chk("mid_up_s3", obs_w, pk(3'd1, 3'b111, 0, 0, 0, 2'd0));
    mark = cyc;
    #2 rst = 1'b1;
    #1 chk("async_reset_mid_up", obs_w, 11'd0);
    ex(11'd0, 1, "reset_seen_by_monitor");
    tick(2);
    en = 1'b0;
    good = 3'b000;
    rst = 1'b0;
    tick(3);
    chk("idle_without_enable", obs_w, 11'd0);
    en = 1'b1;
    mark = cyc;
    ex(pk(3'd1, 3'b001, 0, 0, 0, 2'd0), 1, "up_after_reset");
    tick(2);
    en = 1'b0;
    mark = cyc;
    ex(pk(3'd4, 3'b000, 0, 0, 0, 2'd0), 1, "final_down");
    ex(pk(3'd0, 3'b000, 0, 0, 0, 2'd0), 8, "final_idle");
    tick(12);

    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d pending expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
